// File: rtl/mc_main_control.sv
// Multicycle main control FSM for the 16-bit MIPS-subset datapath.
// Optional instruction counter output enabled by defining MC_MAIN_CONTROL_PERF_EN.
module mc_main_control #(
    parameter int unsigned RST_VECTOR_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [3:0] State,
    output logic       Illegal
`ifdef MC_MAIN_CONTROL_PERF_EN
    ,
    output logic [31:0] InstrCount
`endif
);

    localparam int unsigned SW = 4;
    localparam int unsigned CW = 4;

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_R_EXEC   = 4'd7;
    localparam logic [3:0] S_R_WB     = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_IMM_EXEC = 4'd10;
    localparam logic [3:0] S_IMM_WB   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_SLTI  = 4'b0010;
    localparam logic [3:0] OP_LW    = 4'b0011;
    localparam logic [3:0] OP_SW    = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_J     = 4'b0110;

    logic [SW-1:0] state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          illegal, illegal_nxt;

    // Zero is consumed by the external PCWriteCond gate, not by this FSM.
    logic zero_unused;
    assign zero_unused = Zero;

    // State, reset-wait counter and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RST;
            cnt     <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            illegal <= illegal_nxt;
        end
    end

    assign State   = state;
    assign Illegal = illegal;

    // Next-state and Moore output decode; FETCH outputs are qualified by MemReady
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        illegal_nxt = illegal;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        case (state)
            S_RST: begin
                if (cnt == CW'(RST_VECTOR_WAIT - 1)) begin
                    state_nxt = S_FETCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 2'b11;
                case (Opcode)
                    OP_RTYPE:        state_nxt = S_R_EXEC;
                    OP_ADDI, OP_SLTI: state_nxt = S_IMM_EXEC;
                    OP_LW, OP_SW:    state_nxt = S_MEM_ADDR;
                    OP_BEQ:          state_nxt = S_BRANCH;
                    OP_J:            state_nxt = S_JUMP;
                    default: begin
                        state_nxt   = S_FETCH;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp     = 2'b11;
                state_nxt = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) state_nxt = S_FETCH;
            end
            S_R_EXEC: begin
                ALUSrcA   = 1'b1;
                state_nxt = S_R_WB;
            end
            S_R_WB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_nxt   = S_FETCH;
            end
            S_IMM_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp     = (Opcode == OP_SLTI) ? 2'b10 : 2'b11;
                state_nxt = S_IMM_WB;
            end
            S_IMM_WB: begin
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

`ifdef MC_MAIN_CONTROL_PERF_EN
    // Counts every instruction end (retired or illegal) as a re-entry into FETCH
    logic count_inc;
    assign count_inc = (state_nxt == S_FETCH) && (state != S_FETCH) && (state != S_RST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrCount <= 32'd0;
        end else if (count_inc) begin
            InstrCount <= InstrCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// Directed self-checking bench for mc_main_control.
// Control outputs are compared as one packed word per cycle.
module tb_mc_main_control;

    logic       clk;
    logic       rst_n;
    logic [3:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic [3:0] State;
    logic       Illegal;
`ifdef MC_MAIN_CONTROL_PERF_EN
    logic [31:0] InstrCount;
`endif

    int checks;
    int passed;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUOp}
    logic [15:0] ctl;
    assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp};

    mc_main_control #(.RST_VECTOR_WAIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .State(State), .Illegal(Illegal)
`ifdef MC_MAIN_CONTROL_PERF_EN
        , .InstrCount(InstrCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; MemReady = 1'b1; Opcode = 4'b0000; Zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (State !== 4'd0) $display("FAIL reset_state: got %0d want 0", State);
        else passed++;
        checks++;
        if (ctl !== 16'h0000) $display("FAIL reset_ctl: got %h want 0000", ctl);
        else passed++;
        checks++;
        if (Illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", Illegal);
        else passed++;
        rst_n = 1'b1;
        #1;
        checks++;
        if (State !== 4'd0 || ctl !== 16'h0000)
            $display("FAIL srst_hold: got state %0d ctl %h want state 0 ctl 0000", State, ctl);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (State !== 4'd1) $display("FAIL srst_to_fetch: got %0d want 1", State);
        else passed++;
    endtask

    task automatic test_rtype();
        logic [3:0]  st [5];
        logic [15:0] cv [4];
        st = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        cv = '{16'h9413, 16'h0033, 16'h0040, 16'h0180};
        Opcode = 4'b0000; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (State !== st[i]) $display("FAIL rtype_state[%0d]: got %0d want %0d", i, State, st[i]);
            else passed++;
            if (i < 4) begin
                checks++;
                if (ctl !== cv[i]) $display("FAIL rtype_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
                else passed++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  st [8];
        logic        mr [8];
        logic [15:0] cv [7];
        st = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        cv = '{16'h9413, 16'h0033, 16'h0063, 16'h3000, 16'h3000, 16'h3000, 16'h0280};
        Opcode = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            MemReady = mr[i];
            #1;
            checks++;
            if (State !== st[i]) $display("FAIL lw_state[%0d]: got %0d want %0d", i, State, st[i]);
            else passed++;
            if (i < 7) begin
                checks++;
                if (ctl !== cv[i]) $display("FAIL lw_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
                else passed++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0]  st [6];
        logic        mr [6];
        logic [15:0] cv [5];
        st = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd1};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        cv = '{16'h9413, 16'h0033, 16'h0063, 16'h2800, 16'h2800};
        Opcode = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            MemReady = mr[i];
            #1;
            checks++;
            if (State !== st[i]) $display("FAIL sw_state[%0d]: got %0d want %0d", i, State, st[i]);
            else passed++;
            if (i < 5) begin
                checks++;
                if (ctl !== cv[i]) $display("FAIL sw_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
                else passed++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_slti_beq();
        logic [3:0]  st [8];
        logic [3:0]  op [8];
        logic [15:0] cv [7];
        st = '{4'd1, 4'd2, 4'd10, 4'd11, 4'd1, 4'd2, 4'd9, 4'd1};
        op = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        cv = '{16'h9413, 16'h0033, 16'h0062, 16'h0080, 16'h9413, 16'h0033, 16'h4045};
        MemReady = 1'b1; Zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            Opcode = op[i];
            #1;
            checks++;
            if (State !== st[i]) $display("FAIL slti_beq_state[%0d]: got %0d want %0d", i, State, st[i]);
            else passed++;
            if (i < 7) begin
                checks++;
                if (ctl !== cv[i]) $display("FAIL slti_beq_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
                else passed++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_addi_jump();
        logic [3:0]  st [8];
        logic [3:0]  op [8];
        logic [15:0] cv [7];
        st = '{4'd1, 4'd2, 4'd10, 4'd11, 4'd1, 4'd2, 4'd12, 4'd1};
        op = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd6, 4'd6, 4'd6, 4'd6};
        cv = '{16'h9413, 16'h0033, 16'h0063, 16'h0080, 16'h9413, 16'h0033, 16'h8008};
        MemReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Opcode = op[i];
            #1;
            checks++;
            if (State !== st[i]) $display("FAIL addi_j_state[%0d]: got %0d want %0d", i, State, st[i]);
            else passed++;
            if (i < 7) begin
                checks++;
                if (ctl !== cv[i]) $display("FAIL addi_j_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
                else passed++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_fetch_stall();
        logic [3:0]  st [7];
        logic        mr [7];
        logic [15:0] cv [5];
        st = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd7, 4'd8};
        mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        cv = '{16'h1013, 16'h1013, 16'h1013, 16'h9413, 16'h0033};
        Opcode = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            MemReady = mr[i];
            #1;
            checks++;
            if (State !== st[i]) $display("FAIL stall_state[%0d]: got %0d want %0d", i, State, st[i]);
            else passed++;
            if (i < 5) begin
                checks++;
                if (ctl !== cv[i]) $display("FAIL stall_ctl[%0d]: got %h want %h", i, ctl, cv[i]);
                else passed++;
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (State !== 4'd1) $display("FAIL stall_end: got %0d want 1", State);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] st [4];
        logic       mr [4];
        st = '{4'd1, 4'd2, 4'd3, 4'd4};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0};
        Opcode = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            MemReady = mr[i];
            #1;
            checks++;
            if (State !== st[i]) $display("FAIL midrst_state[%0d]: got %0d want %0d", i, State, st[i]);
            else passed++;
            if (i < 3) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (State !== 4'd0 || MemRead !== 1'b0 || ctl !== 16'h0000)
            $display("FAIL midrst_async: got state %0d memread %b ctl %h want 0 0 0000", State, MemRead, ctl);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1; MemReady = 1'b1;
        #1;
        checks++;
        if (State !== 4'd0) $display("FAIL midrst_srst: got %0d want 0", State);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (State !== 4'd1) $display("FAIL midrst_fetch: got %0d want 1", State);
        else passed++;
    endtask

    task automatic test_illegal();
        Opcode = 4'b1111; MemReady = 1'b1;
        #1;
        checks++;
        if (Illegal !== 1'b0) $display("FAIL illegal_pre: got %b want 0", Illegal);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (State !== 4'd2 || Illegal !== 1'b0)
            $display("FAIL illegal_decode: got state %0d illegal %b want 2 0", State, Illegal);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (State !== 4'd1 || Illegal !== 1'b1)
            $display("FAIL illegal_set: got state %0d illegal %b want 1 1", State, Illegal);
        else passed++;
`ifdef MC_MAIN_CONTROL_PERF_EN
        checks++;
        if (InstrCount !== 32'd1) $display("FAIL instr_count_illegal: got %0d want 1", InstrCount);
        else passed++;
`endif
        Opcode = 4'b0110;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (State !== 4'd1 || Illegal !== 1'b1)
            $display("FAIL illegal_sticky: got state %0d illegal %b want 1 1", State, Illegal);
        else passed++;
`ifdef MC_MAIN_CONTROL_PERF_EN
        checks++;
        if (InstrCount !== 32'd2) $display("FAIL instr_count_jump: got %0d want 2", InstrCount);
        else passed++;
`endif
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_wait();
        test_slti_beq();
        test_addi_jump();
        test_fetch_stall();
        test_reset_mid();
        test_illegal();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
